// File: rtl/dd_scan_receiver_pkg.sv
// Shared widths, types and seven-segment glyph table for the digit-scan receiver.
package dd_scan_receiver_pkg;

   localparam int unsigned SEG_WIDTH   = 8;
   localparam int unsigned GLYPH_WIDTH = 7;
   localparam int unsigned HEX_WIDTH   = 4;
   localparam int unsigned NUM_GLYPHS  = 16;
   localparam int unsigned CNT_WIDTH   = 4;
   localparam int unsigned ERR_WIDTH   = 8;

   typedef logic [SEG_WIDTH-1:0]   seg_t;
   typedef logic [GLYPH_WIDTH-1:0] glyph_t;
   typedef logic [HEX_WIDTH-1:0]   hex_t;

   // One staged digit: decimal point, glyph legality and decoded value.
   typedef struct packed {
      logic dp;
      logic legal;
      hex_t hex;
   } slot_t;

   typedef enum logic [1:0] {
      ST_BLANK    = 2'd0,
      ST_SETTLING = 2'd1,
      ST_HELD     = 2'd2
   } state_e;

   // Segment pattern (a..g in bits 0..6) for hex values 0..F.
   localparam glyph_t GLYPH_TABLE [NUM_GLYPHS] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/dd_scan_receiver_if.sv
// Pin bundle between a multiplexed display driver (gate/segment lines) and dd_scan_receiver.
interface dd_scan_receiver_if #(
   parameter int unsigned DIGITS = 4
);
   logic [DIGITS-1:0]                                    gate_in;
   dd_scan_receiver_pkg::seg_t                           seg_in;
   logic [dd_scan_receiver_pkg::HEX_WIDTH*DIGITS-1:0]    digit_out;
   logic [DIGITS-1:0]                                    dp_out;
   logic [DIGITS-1:0]                                    legal_out;
   logic                                                 frame_valid;
   logic [dd_scan_receiver_pkg::ERR_WIDTH-1:0]           err_cnt;

   modport master (
      output gate_in, seg_in,
      input  digit_out, dp_out, legal_out, frame_valid, err_cnt
   );

   modport slave (
      input  gate_in, seg_in,
      output digit_out, dp_out, legal_out, frame_valid, err_cnt
   );
endinterface

// File: rtl/dd_seg_decoder.sv
// Maps one 7-bit segment pattern to its hex value; unknown patterns give 0 with legal cleared.
module dd_seg_decoder
   import dd_scan_receiver_pkg::*;
(
   input  glyph_t pattern_i,
   output logic   legal_c,
   output hex_t   hex_c
);

   always_comb begin
      legal_c = 1'b0;
      hex_c   = '0;
      for (int unsigned i = 0; i < NUM_GLYPHS; i++) begin
         if (pattern_i == GLYPH_TABLE[i]) begin
            legal_c = 1'b1;
            hex_c   = HEX_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/dd_scan_receiver.sv
// Recovers per-digit hex values from a multiplexed seven-segment display scan.
// Define DD_SCAN_RX_SYNC_EN to pass gate_in/seg_in through a 2-flop synchronizer (+2 cycles).
module dd_scan_receiver
   import dd_scan_receiver_pkg::*;
#(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned SETTLE = 3
) (
   input logic               clk,
   input logic               rst,
   dd_scan_receiver_if.slave bus
);

   localparam int unsigned IDX_WIDTH = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [DIGITS-1:0] gate_w;
   seg_t              seg_w;

`ifdef DD_SCAN_RX_SYNC_EN
   logic [DIGITS-1:0] gate_s1_q, gate_s2_q;
   seg_t              seg_s1_q, seg_s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         gate_s1_q <= '0;
         gate_s2_q <= '0;
         seg_s1_q  <= '0;
         seg_s2_q  <= '0;
      end else begin
         gate_s1_q <= bus.gate_in;
         gate_s2_q <= gate_s1_q;
         seg_s1_q  <= bus.seg_in;
         seg_s2_q  <= seg_s1_q;
      end
   end

   assign gate_w = gate_s2_q;
   assign seg_w  = seg_s2_q;
`else
   assign gate_w = bus.gate_in;
   assign seg_w  = bus.seg_in;
`endif

   state_e                     state_q, state_d;
   logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
   logic [DIGITS-1:0]          gate_q, gate_d;
   logic                       mh_q, mh_d;
   logic [ERR_WIDTH-1:0]       err_q, err_d;
   logic [DIGITS-1:0]          mask_q, mask_d;
   slot_t [DIGITS-1:0]         stage_q, stage_d;
   logic [HEX_WIDTH*DIGITS-1:0] digit_q, digit_d;
   logic [DIGITS-1:0]          dp_q, dp_d;
   logic [DIGITS-1:0]          legal_q, legal_d;
   logic                       frame_q, frame_d;

   logic                       one_hot_c, multi_hot_c, restart_c, capture_c;
   logic [IDX_WIDTH-1:0]       idx_c;
   logic                       dec_legal_c;
   hex_t                       dec_hex_c;

   assign one_hot_c   = $onehot(gate_w);
   assign multi_hot_c = (gate_w != '0) && !one_hot_c;
   // A new activation starts whenever we come out of blanking or the selected digit changes.
   assign restart_c   = (state_q == ST_BLANK) || (gate_w != gate_q);

   always_comb begin
      idx_c = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (gate_w[i]) idx_c = IDX_WIDTH'(i);
      end
   end

   dd_seg_decoder u_dec (
      .pattern_i (seg_w[GLYPH_WIDTH-1:0]),
      .legal_c   (dec_legal_c),
      .hex_c     (dec_hex_c)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_BLANK;
      else     state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      if (!one_hot_c)     state_d = ST_BLANK;
      else if (capture_c) state_d = ST_HELD;
      else if (restart_c) state_d = ST_SETTLING;
   end

   // FSM outputs: stability counter and capture strobe (HELD never captures again)
   always_comb begin
      cnt_d     = '0;
      gate_d    = gate_q;
      capture_c = 1'b0;
      if (one_hot_c) begin
         gate_d = gate_w;
         if (restart_c)                   cnt_d = CNT_WIDTH'(1);
         else if (state_q == ST_SETTLING) cnt_d = cnt_q + CNT_WIDTH'(1);
         else                             cnt_d = cnt_q;
         capture_c = (restart_c || (state_q == ST_SETTLING)) && (cnt_d == CNT_WIDTH'(SETTLE));
      end
   end

   // Staging, frame assembly and error counting
   always_comb begin
      stage_d = stage_q;
      mask_d  = mask_q;
      digit_d = digit_q;
      dp_d    = dp_q;
      legal_d = legal_q;
      frame_d = 1'b0;
      err_d   = err_q;
      mh_d    = multi_hot_c;

      if (mask_q == '1) begin
         frame_d = 1'b1;
         mask_d  = '0;
         for (int unsigned i = 0; i < DIGITS; i++) begin
            digit_d[HEX_WIDTH*i +: HEX_WIDTH] = stage_q[i].hex;
            dp_d[i]    = stage_q[i].dp;
            legal_d[i] = stage_q[i].legal;
         end
      end

      // Applied after the frame load so a coincident capture opens the next frame.
      if (capture_c) begin
         stage_d[idx_c] = {seg_w[SEG_WIDTH-1], dec_legal_c, dec_hex_c};
         mask_d[idx_c]  = 1'b1;
      end

      if (multi_hot_c && !mh_q && (err_q != '1)) err_d = err_q + ERR_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         gate_q  <= '0;
         mh_q    <= 1'b0;
         err_q   <= '0;
         mask_q  <= '0;
         stage_q <= '0;
         digit_q <= '0;
         dp_q    <= '0;
         legal_q <= '0;
         frame_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         gate_q  <= gate_d;
         mh_q    <= mh_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
         stage_q <= stage_d;
         digit_q <= digit_d;
         dp_q    <= dp_d;
         legal_q <= legal_d;
         frame_q <= frame_d;
      end
   end

   assign bus.digit_out   = digit_q;
   assign bus.dp_out      = dp_q;
   assign bus.legal_out   = legal_q;
   assign bus.frame_valid = frame_q;
   assign bus.err_cnt     = err_q;

endmodule

// File: tb/tb_dd_scan_receiver.sv
// Bench for dd_scan_receiver: directed scans plus random scan traffic against a behavioural model.
module tb_dd_scan_receiver;

   localparam int unsigned D      = 4;
   localparam int unsigned SETTLE = 3;
`ifdef DD_SCAN_RX_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dd_scan_receiver_if #(.DIGITS(D)) bus();

   dd_scan_receiver #(.DIGITS(D), .SETTLE(SETTLE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp   = 0;
   int n_fail  = 0;
   int fv_seen = 0;
   bit chk_on  = 1'b0;

   logic [6:0] glyphs [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Model: raw captured bytes per digit, decoded only when a frame is presented.
   logic [7:0]     st_seg [D] = '{default: '0};
   logic [D-1:0]   m_mask  = '0;
   logic [4*D-1:0] m_digit = '0;
   logic [D-1:0]   m_dp    = '0;
   logic [D-1:0]   m_legal = '0;
   logic           m_fv    = 1'b0;
   int             m_err   = 0;
   int             run     = 0;
   logic [D-1:0]   prev_g  = '0;
   bit             prev_mh = 1'b0;
`ifdef DD_SCAN_RX_SYNC_EN
   logic [D-1:0]   p1_g = '0, p2_g = '0;
   logic [7:0]     p1_s = '0, p2_s = '0;
`endif

   function automatic logic [4:0] tb_decode(input logic [6:0] p);
      for (int i = 0; i < 16; i++) begin
         if (glyphs[i] == p) return {1'b1, 4'(i)};
      end
      return 5'b0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic [D-1:0] g_in, input logic [7:0] s_in);
      logic [D-1:0] g;
      logic [7:0]   s;
      logic [4:0]   dec;
      if (rst) begin
         m_mask = '0; m_digit = '0; m_dp = '0; m_legal = '0; m_fv = 1'b0; m_err = 0;
         run = 0; prev_g = '0; prev_mh = 1'b0;
         for (int i = 0; i < D; i++) st_seg[i] = '0;
`ifdef DD_SCAN_RX_SYNC_EN
         p1_g = '0; p2_g = '0; p1_s = '0; p2_s = '0;
`endif
         return;
      end
`ifdef DD_SCAN_RX_SYNC_EN
      g = p2_g; s = p2_s;
      p2_g = p1_g; p2_s = p1_s;
      p1_g = g_in; p1_s = s_in;
`else
      g = g_in; s = s_in;
`endif
      m_fv = (m_mask == {D{1'b1}});
      if (m_fv) begin
         m_mask = '0;
         for (int i = 0; i < D; i++) begin
            dec = tb_decode(st_seg[i][6:0]);
            m_digit[4*i +: 4] = dec[3:0];
            m_legal[i] = dec[4];
            m_dp[i]    = st_seg[i][7];
         end
      end
      if ($countones(g) == 0) begin
         run = 0;
         prev_mh = 1'b0;
      end else if ($countones(g) > 1) begin
         run = 0;
         if (!prev_mh && m_err < 255) m_err++;
         prev_mh = 1'b1;
      end else begin
         prev_mh = 1'b0;
         run = (g == prev_g && run > 0) ? run + 1 : 1;
         prev_g = g;
         if (run == SETTLE) begin
            for (int i = 0; i < D; i++) begin
               if (g[i]) begin
                  st_seg[i] = s;
                  m_mask[i] = 1'b1;
               end
            end
         end
      end
   endtask

   // Inputs change on the falling edge; the model advances with each rising edge.
   task automatic tick(input logic [D-1:0] g, input logic [7:0] s);
      bus.gate_in = g;
      bus.seg_in  = s;
      @(posedge clk);
      model_step(g, s);
      @(negedge clk);
   endtask

   task automatic scan(input logic [D-1:0] g, input logic [7:0] s, input int n);
      for (int i = 0; i < n; i++) tick(g, s);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick('0, '0);
      tick('0, '0);
      rst = 1'b0;
      chk("rst_digit", 32'(bus.digit_out), 32'h0);
      chk("rst_err", 32'(bus.err_cnt), 32'h0);
      chk("rst_fv", 32'(bus.frame_valid), 32'h0);
   endtask

   function automatic logic [7:0] rand_seg();
      logic [6:0] gl;
      if ($urandom_range(0, 3) != 0) begin
         gl = glyphs[$urandom_range(0, 15)];
         return {1'($urandom_range(0, 1)), gl};
      end
      return 8'($urandom);
   endfunction

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("digit_out", 32'(bus.digit_out), 32'(m_digit));
         chk("dp_out", 32'(bus.dp_out), 32'(m_dp));
         chk("legal_out", 32'(bus.legal_out), 32'(m_legal));
         chk("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
         chk("err_cnt", 32'(bus.err_cnt), 32'(m_err));
         if (bus.frame_valid === 1'b1) fv_seen++;
      end
   end

   initial begin
      int f0;
      int kind;
      int len;
      int a;
      int b;
      logic [D-1:0] g;
      logic [7:0]   s;

      bus.gate_in = '0;
      bus.seg_in  = '0;
      @(negedge clk);
      rst = 1'b1;
      tick('0, '0);
      chk_on = 1'b1;
      do_reset();

      // Plain frame 4321
      f0 = fv_seen;
      scan(4'b0001, 8'h06, 8);
      scan(4'b0010, 8'h5B, 8);
      scan(4'b0100, 8'h4F, 8);
      scan(4'b1000, 8'h66, 8);
      scan('0, '0, 3 + LAT);
      chk("frame1_count", 32'(fv_seen - f0), 32'd1);
      chk("frame1_digit", 32'(bus.digit_out), 32'h4321);
      chk("frame1_legal", 32'(bus.legal_out), 32'hF);
      chk("frame1_err", 32'(bus.err_cnt), 32'h0);

      // Digit 1 held one cycle short of SETTLE is not captured
      do_reset();
      f0 = fv_seen;
      scan(4'b0001, 8'h3F, 8);
      scan(4'b0100, 8'h5B, 8);
      scan(4'b1000, 8'h4F, 8);
      scan(4'b0010, 8'h06, 2);
      scan('0, '0, 4 + LAT);
      chk("short_gate_nofv", 32'(fv_seen - f0), 32'd0);
      scan(4'b0010, 8'h06, 3);
      scan('0, '0, 3 + LAT);
      chk("short_gate_fv", 32'(fv_seen - f0), 32'd1);
      chk("short_gate_digit", 32'(bus.digit_out), 32'h3210);

      // Multi-hot events count per entry
      do_reset();
      scan(4'b0011, 8'h00, 5);
      scan('0, '0, 1);
      scan(4'b0101, 8'h00, 1);
      scan('0, '0, 2 + LAT);
      chk("multihot_err2", 32'(bus.err_cnt), 32'd2);

      // Illegal glyph on digit 2, dp on digit 0
      do_reset();
      scan(4'b0001, 8'hBF, 8);
      scan(4'b0010, 8'h06, 8);
      scan(4'b0100, 8'h49, 8);
      scan(4'b1000, 8'h4F, 8);
      scan('0, '0, 3 + LAT);
      chk("illegal_digit", 32'(bus.digit_out), 32'h3010);
      chk("illegal_legal", 32'(bus.legal_out), 32'b1011);
      chk("illegal_dp", 32'(bus.dp_out), 32'b0001);

      // Reset mid-frame discards the partial frame
      do_reset();
      scan(4'b0001, 8'h06, 4);
      scan(4'b0010, 8'h5B, 4);
      scan(4'b0100, 8'h4F, 4);
      do_reset();
      f0 = fv_seen;
      scan(4'b0001, 8'h6D, 4);
      scan(4'b0010, 8'h7D, 4);
      scan(4'b0100, 8'h07, 4);
      scan(4'b1000, 8'h7F, 2);
      chk("midrst_nofv", 32'(fv_seen - f0), 32'd0);
      scan(4'b1000, 8'h7F, 6);
      scan('0, '0, 3 + LAT);
      chk("midrst_fv", 32'(fv_seen - f0), 32'd1);
      chk("midrst_digit", 32'(bus.digit_out), 32'h8765);

      // err_cnt saturation
      do_reset();
      for (int i = 0; i < 256; i++) begin
         tick(4'b0011, 8'h00);
         tick('0, '0);
      end
      scan('0, '0, 2 + LAT);
      chk("err_sat_256", 32'(bus.err_cnt), 32'd255);
      for (int i = 0; i < 44; i++) begin
         tick(4'b1100, 8'h00);
         tick('0, '0);
      end
      scan('0, '0, 2 + LAT);
      chk("err_sat_300", 32'(bus.err_cnt), 32'd255);

      // Random scan traffic
      do_reset();
      for (int blk = 0; blk < 600; blk++) begin
         kind = int'($urandom_range(0, 99));
         len  = int'($urandom_range(1, 6));
         a    = int'($urandom_range(0, D - 1));
         if (kind < 72) begin
            g = D'(1) << a;
         end else if (kind < 86) begin
            g = '0;
         end else begin
            b = (a + 1 + int'($urandom_range(0, D - 2))) % D;
            g = (D'(1) << a) | (D'(1) << b);
         end
         s = rand_seg();
         for (int c = 0; c < len; c++) begin
            if ($urandom_range(0, 3) == 0) s = rand_seg();
            tick(g, s);
         end
         if ($urandom_range(0, 149) == 0) begin
            rst = 1'b1;
            tick('0, '0);
            rst = 1'b0;
         end
      end
      scan('0, '0, 4 + LAT);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dd_scan_receiver.md
DD_SCAN_RECEIVER -- requirements
Module: dd_scan_receiver

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed display digits (gate lines).
REQ-002 Parameter SETTLE, default 3: consecutive cycles a one-hot gate must hold before sampling (1..15).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 gate_in  input  DIGITS  digit select; one-hot active-high, all-zero = blanking.
REQ-006 seg_in  input  8  segment lines, active-high; bit0..6 = a..g, bit7 = dp.
REQ-007 digit_out  output  4*DIGITS  decoded hex value per digit; digit i in bits [4i+3:4i].
REQ-008 dp_out  output  DIGITS  decimal-point state per digit.
REQ-009 legal_out  output  DIGITS  1 = the digit's pattern decoded to a legal hex glyph.
REQ-010 frame_valid  output  1  one-cycle pulse; digit_out/dp_out/legal_out updated this cycle.
REQ-011 err_cnt  output  8  count of multi-hot gate events, saturating.

Function
REQ-012 The FSM SHALL have three states: BLANK (gate zero or multi-hot), SETTLING (one-hot, counting), HELD (digit captured, awaiting gate change).
REQ-013 BLANK -> SETTLING when gate is one-hot; stable count loads 1.
REQ-014 In SETTLING, an identical gate SHALL increment count; on the cycle count reaches SETTLE, seg_in SHALL be captured into staging slot for that gate index, state -> HELD.
REQ-015 In SETTLING/HELD, a different one-hot gate SHALL restart SETTLING with count 1; zero gate -> BLANK.
REQ-016 Each gate activation SHALL be captured at most once; HELD ignores seg_in changes.
REQ-017 Multi-hot gate in any state SHALL go to BLANK, increment err_cnt by 1 per entry (not per cycle), saturating at 255.
REQ-018 A per-digit captured mask SHALL set on capture; recapture of an already-set digit SHALL overwrite staging.
REQ-019 On the cycle after the mask becomes all-ones, outputs SHALL load from staging, frame_valid SHALL pulse 1 cycle, and the mask SHALL clear.
REQ-020 A capture coinciding with the frame-load cycle SHALL be written to staging and set the new mask bit (not lost).
REQ-021 Decode: 7-bit patterns for 0-F (0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F,0x77,0x7C,0x39,0x5E,0x79,0x71) -> hex, legal=1; any other -> value 0, legal=0.
REQ-022 dp SHALL be bit7 of the captured pattern, independent of legality.

Reset
REQ-023 rst SHALL clear digit_out, dp_out, legal_out, frame_valid, err_cnt, staging, mask, count, and place FSM in BLANK.
REQ-024 rst mid-frame SHALL discard partial frame; no frame_valid until a full new frame is captured.
REQ-025 Synchronizer flops (if present) SHALL reset to zero.

Configuration
REQ-026 Macro DD_SCAN_RX_SYNC_EN defined: gate_in and seg_in pass through a 2-flop synchronizer; all latencies +2 cycles.
REQ-027 Macro undefined: inputs sampled directly; capture on the SETTLE-th cycle of stable gate as stated.

Structure
REQ-028 Shared package SHALL hold SEG_WIDTH=8, the segment-to-hex decode constants, and typedefs for segment pattern and hex digit.
REQ-029 Combinational sub-module dd_seg_decoder SHALL map one 7-bit pattern to {legal, hex}; instantiated once on the staging write path or DIGITS times on load.

Verification
REQ-030 Gates 0001,0010,0100,1000 each 8 cycles with seg 0x06,0x5B,0x4F,0x66 -> one frame_valid, digit_out=0x4321, legal_out=1111, err_cnt=0.
REQ-031 SETTLE=3, gate 0010 held 2 cycles then 0000 -> digit 1 not captured, no frame_valid.
REQ-032 Gate 0011 for 5 cycles, then 0000, then 0101 -> err_cnt=2.
REQ-033 Full frame with digit 2 seg 0x49 and dp set on digit 0 -> digit 2 value 0, legal_out=1011, dp_out=0001.
REQ-034 rst asserted after 3 of 4 digits captured, then 4 digits rescanned -> exactly one frame_valid, after the 4th new capture.
REQ-035 300 multi-hot entries -> err_cnt=255, no wrap.
